// File: rtl/adc_delay_cal.sv
`default_nettype none
// ============================================================================
// Module   : adc_delay_cal
// Function : Sweeps the 32 ADC input-delay taps while the ADC emits a fixed
//            test pattern, records which taps pass, and loads the centre of
//            the longest passing window (or restores the previous tap).
// Revision : 1.0 - initial release
// ============================================================================
module adc_delay_cal #(
  parameter int          SETTLE_CYCLES = 64,
  parameter int          SAMPLE_CYCLES = 1024,
  parameter int          LOAD_CYCLES   = 4,
  parameter logic [25:0] EXP_PATTERN   = 26'h2AA_AAAA,
  parameter logic [25:0] CMP_MASK      = 26'h3FF_DFFE,
  parameter logic [4:0]  DEFAULT_TAP   = 5'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cal_start,
  input  logic        acq_enabled,
  input  logic [25:0] adc_dat,
  output logic [4:0]  delay_tap,
  output logic        delay_load,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        cal_fail,
  output logic [31:0] tap_pass_map,
  output logic [4:0]  win_first,
  output logic [4:0]  win_last
);

  // One shared phase counter covers the load, settle and sample phases.
  localparam int c_max_a   = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int c_max_len = (c_max_a > LOAD_CYCLES) ? c_max_a : LOAD_CYCLES;
  localparam int c_cnt_w   = $clog2(c_max_len + 1);

  localparam logic [c_cnt_w-1:0] c_load_last   = c_cnt_w'(LOAD_CYCLES);
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_sample_last = c_cnt_w'(SAMPLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_NEXT   = 3'd4,
    S_CHOOSE = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [4:0]           r_idx;
  logic [4:0]           r_prev_tap;
  logic                 r_pass;
  logic                 r_fail_pend;
  logic [4:0]           r_cur_start;
  logic [5:0]           r_cur_len;
  logic [4:0]           r_best_start;
  logic [5:0]           r_best_len;

  logic                 w_mismatch;
  logic                 w_abort;
  logic [5:0]           w_new_len;
  logic [4:0]           w_span;
  logic [4:0]           w_centre;

  // Over-range bits are masked out; any other differing bit fails the word.
  assign w_mismatch = |((adc_dat ^ EXP_PATTERN) & CMP_MASK);

  // Acquisition takes priority over an in-flight sweep, except once the
  // final load is already under way.
  assign w_abort = acq_enabled && (r_state != S_IDLE) && (r_state != S_FINISH);

  assign w_new_len = r_cur_len + 6'd1;
  // best_len is 1..32 when used, so len-1 always fits in 5 bits.
  assign w_span    = r_best_len[4:0] - 5'd1;
  assign w_centre  = r_best_start + (w_span >> 1);

  // Calibration sequencer: tap sweep, window tracking and final tap load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= 5'd0;
      r_prev_tap   <= DEFAULT_TAP;
      r_pass       <= 1'b0;
      r_fail_pend  <= 1'b0;
      r_cur_start  <= 5'd0;
      r_cur_len    <= 6'd0;
      r_best_start <= 5'd0;
      r_best_len   <= 6'd0;
      delay_tap    <= DEFAULT_TAP;
      delay_load   <= 1'b0;
      cal_busy     <= 1'b0;
      cal_done     <= 1'b0;
      cal_fail     <= 1'b0;
      tap_pass_map <= 32'd0;
      win_first    <= 5'd0;
      win_last     <= 5'd0;
    end else begin
      delay_load <= 1'b0;
      if (w_abort) begin
        delay_tap   <= r_prev_tap;
        r_fail_pend <= 1'b1;
        r_cnt       <= '0;
        r_state     <= S_FINISH;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cal_start && !acq_enabled) begin
              r_prev_tap   <= delay_tap;
              cal_done     <= 1'b0;
              cal_fail     <= 1'b0;
              tap_pass_map <= 32'd0;
              win_first    <= 5'd0;
              win_last     <= 5'd0;
              r_cur_start  <= 5'd0;
              r_cur_len    <= 6'd0;
              r_best_start <= 5'd0;
              r_best_len   <= 6'd0;
              r_fail_pend  <= 1'b0;
              r_idx        <= 5'd0;
              r_cnt        <= '0;
              cal_busy     <= 1'b1;
              r_state      <= S_LOAD;
            end
          end
          S_LOAD: begin
            // Tap changes first; the strobe follows one clock later.
            if (r_cnt == '0) begin
              delay_tap <= r_idx;
            end else begin
              delay_load <= 1'b1;
            end
            if (r_cnt == c_load_last) begin
              r_cnt   <= '0;
              r_state <= S_SETTLE;
            end else begin
              r_cnt <= r_cnt + c_cnt_w'(1);
            end
          end
          S_SETTLE: begin
            if (r_cnt == c_settle_last) begin
              r_cnt   <= '0;
              r_pass  <= 1'b1;
              r_state <= S_SAMPLE;
            end else begin
              r_cnt <= r_cnt + c_cnt_w'(1);
            end
          end
          S_SAMPLE: begin
            r_pass <= r_pass & ~w_mismatch;
            if (r_cnt == c_sample_last) begin
              r_cnt   <= '0;
              r_state <= S_NEXT;
            end else begin
              r_cnt <= r_cnt + c_cnt_w'(1);
            end
          end
          S_NEXT: begin
            tap_pass_map[r_idx] <= r_pass;
            if (r_pass) begin
              r_cur_len <= w_new_len;
              // Strictly longer only, so an equal later run never displaces
              // the earlier one.
              if (w_new_len > r_best_len) begin
                r_best_len   <= w_new_len;
                r_best_start <= r_cur_start;
              end
            end else begin
              r_cur_len   <= 6'd0;
              r_cur_start <= r_idx + 5'd1;
            end
            if (r_idx == 5'd31) begin
              r_state <= S_CHOOSE;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_cnt   <= '0;
              r_state <= S_LOAD;
            end
          end
          S_CHOOSE: begin
            if (r_best_len == 6'd0) begin
              delay_tap   <= r_prev_tap;
              r_fail_pend <= 1'b1;
            end else begin
              delay_tap <= w_centre;
              win_first <= r_best_start;
              win_last  <= r_best_start + w_span;
            end
            r_cnt   <= '0;
            r_state <= S_FINISH;
          end
          S_FINISH: begin
            if (r_cnt == c_load_last) begin
              r_cnt    <= '0;
              cal_busy <= 1'b0;
              cal_done <= ~r_fail_pend;
              cal_fail <= r_fail_pend;
              r_state  <= S_IDLE;
            end else begin
              delay_load <= 1'b1;
              r_cnt      <= r_cnt + c_cnt_w'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_delay_cal.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_delay_cal
// Function : Self-checking bench for adc_delay_cal with shortened settle and
//            sample phases and a tap-dependent ADC word source.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_delay_cal;

  localparam int          L   = 4;
  localparam int          S   = 4;
  localparam int          P   = 16;
  localparam logic [25:0] EXP = 26'h2AA_AAAA;
  localparam logic [25:0] MSK = 26'h3FF_DFFE;
  localparam int          SWEEP = 32 * (L + S + P + 2);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cal_start = 1'b0;
  logic        acq_enabled = 1'b0;
  logic [25:0] adc_dat;
  logic [4:0]  delay_tap;
  logic        delay_load;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_fail;
  logic [31:0] tap_pass_map;
  logic [4:0]  win_first;
  logic [4:0]  win_last;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] pset = 32'd0;    // taps at which the ADC word is clean
  logic [4:0]  exp_tap = 5'd0;  // tap the bench expects to be loaded
  int          load_hi = 0;
  int          pulse_len = 0;

  adc_delay_cal #(
    .SETTLE_CYCLES (S),
    .SAMPLE_CYCLES (P),
    .LOAD_CYCLES   (L),
    .EXP_PATTERN   (EXP),
    .CMP_MASK      (MSK),
    .DEFAULT_TAP   (5'd0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cal_start    (cal_start),
    .acq_enabled  (acq_enabled),
    .adc_dat      (adc_dat),
    .delay_tap    (delay_tap),
    .delay_load   (delay_load),
    .cal_busy     (cal_busy),
    .cal_done     (cal_done),
    .cal_fail     (cal_fail),
    .tap_pass_map (tap_pass_map),
    .win_first    (win_first),
    .win_last     (win_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Longest run of passing taps (first one on a tie, no wrap) and its centre.
  task automatic model(input logic [31:0] ps, input logic [4:0] prev,
                       output logic [4:0] tap, output logic [4:0] first,
                       output logic [4:0] last, output logic ok);
    int best_len;
    int best_start;
    int t;
    int s;
    best_len = 0;
    best_start = 0;
    t = 0;
    while (t < 32) begin
      if (ps[t]) begin
        s = t;
        while (t < 32 && ps[t]) t++;
        if (t - s > best_len) begin
          best_len = t - s;
          best_start = s;
        end
      end else begin
        t++;
      end
    end
    ok    = (best_len > 0);
    tap   = ok ? 5'(best_start + (best_len - 1) / 2) : prev;
    first = ok ? 5'(best_start) : 5'd0;
    last  = ok ? 5'(best_start + best_len - 1) : 5'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tap"},  32'(delay_tap), 32'd0);
    check({tag, "_load"}, 32'(delay_load), 32'd0);
    check({tag, "_busy"}, 32'(cal_busy), 32'd0);
    check({tag, "_done"}, 32'(cal_done), 32'd0);
    check({tag, "_fail"}, 32'(cal_fail), 32'd0);
    check({tag, "_map"},  tap_pass_map, 32'd0);
    check({tag, "_wf"},   32'(win_first), 32'd0);
    check({tag, "_wl"},   32'(win_last), 32'd0);
  endtask

  // Full calibration with cal_start held for 'hold' clocks.
  task automatic run_cal(input logic [31:0] ps, input int hold, input string tag);
    logic [4:0] et;
    logic [4:0] ef;
    logic [4:0] el;
    logic       ok;
    int         cyc;
    pset = ps;
    model(ps, exp_tap, et, ef, el, ok);
    load_hi = 0;
    cal_start = 1'b1;
    repeat (hold) @(negedge clk);
    cal_start = 1'b0;
    check({tag, "_busy_rise"}, 32'(cal_busy), 32'd1);
    cyc = 0;
    while (cal_busy === 1'b1 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_timeout"}, 32'(cal_busy), 32'd0);
    check({tag, "_map"},  tap_pass_map, ps);
    check({tag, "_tap"},  32'(delay_tap), 32'(et));
    check({tag, "_wf"},   32'(win_first), 32'(ef));
    check({tag, "_wl"},   32'(win_last), 32'(el));
    check({tag, "_done"}, 32'(cal_done), 32'(ok));
    check({tag, "_fail"}, 32'(cal_fail), 32'(!ok));
    check({tag, "_loads"}, 32'(load_hi), 32'(33 * L));
    if (hold == 1)
      check({tag, "_dur"}, 32'(cyc >= SWEEP + L && cyc <= SWEEP + L + 4), 32'd1);
    repeat (12) @(negedge clk);
    check({tag, "_idle_busy"}, 32'(cal_busy), 32'd0);
    check({tag, "_idle_loads"}, 32'(load_hi), 32'(33 * L));
    exp_tap = et;
  endtask

  // Returns at the first negedge after the strobe for 'tap' has ended,
  // which is the start of that tap's settle phase.
  task automatic wait_settle(input logic [4:0] tap, input string tag);
    int cyc;
    cyc = 0;
    while (!(delay_tap == tap && delay_load === 1'b1) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_wait_load"}, 32'(cyc < 2000), 32'd1);
    cyc = 0;
    while (delay_load === 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_wait_settle"}, 32'(cyc < 50), 32'd1);
  endtask

  initial begin
    logic [31:0] ps;
    int          cyc;

    fork
      // ADC word source: clean pattern (with random over-range bits) on
      // passing taps, a corrupted compared bit on every other tap.
      forever begin
        logic [25:0] r;
        @(negedge clk);
        r = 26'($urandom);
        if (pset[delay_tap]) begin
          adc_dat = EXP ^ (r & ~MSK);
        end else begin
          r = r & MSK;
          if (r == 26'd0) r = 26'h2;
          adc_dat = EXP ^ r;
        end
      end
      // Every load strobe is exactly L clocks wide.
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          pulse_len = 0;
        end else if (delay_load === 1'b1) begin
          pulse_len++;
          load_hi++;
        end else if (pulse_len != 0) begin
          check("load_width", 32'(pulse_len), 32'(L));
          pulse_len = 0;
        end
      end
    join_none

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Start request while acquisition is enabled is ignored.
    acq_enabled = 1'b1;
    load_hi = 0;
    cal_start = 1'b1;
    repeat (2) @(negedge clk);
    cal_start = 1'b0;
    repeat (5) @(negedge clk);
    check("acq_block_busy", 32'(cal_busy), 32'd0);
    check("acq_block_loads", 32'(load_hi), 32'd0);
    acq_enabled = 1'b0;
    @(negedge clk);

    run_cal(32'h001F_FC00, 1, "win10_20");
    run_cal(32'h00F0_003C, 1, "tie");
    run_cal(32'hF000_000F, 1, "nowrap");
    run_cal(32'h0000_01C0, 1, "prev7");
    run_cal(32'h0000_0000, 1, "allfail");
    run_cal(32'h0000_0700, 1, "prev9");

    // Abort during the sample phase of tap 12.
    ps = $urandom;
    pset = ps;
    load_hi = 0;
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    wait_settle(5'd12, "abort");
    repeat (S + 4) @(negedge clk);
    acq_enabled = 1'b1;
    cyc = 0;
    while (cal_busy === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_timeout", 32'(cal_busy), 32'd0);
    check("abort_tap",  32'(delay_tap), 32'(exp_tap));
    check("abort_fail", 32'(cal_fail), 32'd1);
    check("abort_done", 32'(cal_done), 32'd0);
    check("abort_map",  tap_pass_map, ps & 32'h0000_0FFF);
    check("abort_wf",   32'(win_first), 32'd0);
    check("abort_wl",   32'(win_last), 32'd0);
    check("abort_loads", 32'(load_hi), 32'(13 * L + L));
    acq_enabled = 1'b0;
    @(negedge clk);

    run_cal(32'hFFFF_FFFF, 1, "allpass");

    for (int i = 0; i < 4; i++) begin
      run_cal($urandom & $urandom, 1, $sformatf("rand%0d", i));
    end

    run_cal($urandom | $urandom, 10, "hold10");

    // Reset in the middle of a sweep.
    pset = $urandom;
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    wait_settle(5'd5, "midreset");
    repeat (S + 4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    load_hi = 0;
    repeat (40) @(negedge clk);
    check("postreset_loads", 32'(load_hi), 32'd0);
    check("postreset_busy", 32'(cal_busy), 32'd0);
    check("postreset_tap", 32'(delay_tap), 32'd0);
    exp_tap = 5'd0;

    run_cal(32'h0000_3E00, 1, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
